// File: rtl/pll_lock_sequencer.sv
// PLL acquisition/lock-tracking sequencer: gates detector windows,
// debounces the per-window lock verdict and steps the coarse band on timeout.
module pll_lock_sequencer #(
    parameter int WIN_BITS    = 4,
    parameter int SETTLE_BITS = 8,
    parameter int CONSEC_BITS = 3,
    parameter int BAND_BITS   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [BAND_BITS-1:0]   bandInit,
    input  logic [SETTLE_BITS-1:0] settleCycles,
    input  logic [CONSEC_BITS-1:0] lockCount,
    input  logic [CONSEC_BITS-1:0] unlockCount,
    input  logic [7:0]             timeoutWindows,
    input  logic                   ldLocked,
    output logic                   ldDivideEnable,
    output logic [BAND_BITS-1:0]   bandSel,
    output logic                   bandStep,
    output logic                   pllLocked,
    output logic                   lossOfLock,
    output logic                   acqFail,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_ACQUIRE = 3'd2,
        S_LOCKED  = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    localparam logic [CONSEC_BITS-1:0] CONSEC_MAX = '1;
    localparam logic [BAND_BITS-1:0]   BAND_MAX   = '1;

    state_t                 cur_st, nxt_st;
    logic [WIN_BITS-1:0]    win_cnt;
    logic                   past_first;
    logic                   div_en, strobe;
    logic [SETTLE_BITS-1:0] settle_cnt, settle_nxt;
    logic [CONSEC_BITS-1:0] good_cnt, good_nxt, good_inc;
    logic [CONSEC_BITS-1:0] bad_cnt, bad_nxt, bad_inc;
    logic [CONSEC_BITS-1:0] lock_thr, unlock_thr;
    logic [7:0]             win_total, total_nxt, total_inc;
    logic [BAND_BITS-1:0]   band_q, band_nxt;
    logic                   step_q, step_nxt;
    logic                   lol_q, lol_nxt;
    logic                   fail_q, fail_nxt;

    assign div_en = (cur_st == S_ACQUIRE) || (cur_st == S_LOCKED);

    // First window after enable is skipped: detector has no verdict yet.
    assign strobe = div_en && (win_cnt == WIN_BITS'(1)) && past_first;

    assign lock_thr   = (lockCount == '0) ? CONSEC_BITS'(1) : lockCount;
    assign unlock_thr = (unlockCount == '0) ? CONSEC_BITS'(1) : unlockCount;

    assign good_inc  = (good_cnt == CONSEC_MAX) ? good_cnt : good_cnt + CONSEC_BITS'(1);
    assign bad_inc   = (bad_cnt == CONSEC_MAX) ? bad_cnt : bad_cnt + CONSEC_BITS'(1);
    assign total_inc = (win_total == 8'hff) ? win_total : win_total + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_cnt    <= '0;
            past_first <= 1'b0;
        end else if (!div_en) begin
            win_cnt    <= '0;
            past_first <= 1'b0;
        end else begin
            win_cnt <= win_cnt + WIN_BITS'(1);
            if (win_cnt == '1) past_first <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_st     <= S_IDLE;
            settle_cnt <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            win_total  <= '0;
            band_q     <= '0;
            step_q     <= 1'b0;
            lol_q      <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            settle_cnt <= settle_nxt;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
            win_total  <= total_nxt;
            band_q     <= band_nxt;
            step_q     <= step_nxt;
            lol_q      <= lol_nxt;
            fail_q     <= fail_nxt;
        end
    end

    always_comb begin
        nxt_st     = cur_st;
        settle_nxt = settle_cnt;
        good_nxt   = good_cnt;
        bad_nxt    = bad_cnt;
        total_nxt  = win_total;
        band_nxt   = band_q;
        step_nxt   = 1'b0;
        lol_nxt    = 1'b0;
        fail_nxt   = fail_q;
        if (!enable) begin
            nxt_st = S_IDLE;
        end else begin
            unique case (cur_st)
                S_IDLE: begin
                    nxt_st     = S_SETTLE;
                    band_nxt   = bandInit;
                    settle_nxt = settleCycles;
                    fail_nxt   = 1'b0;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        nxt_st    = S_ACQUIRE;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                        total_nxt = '0;
                    end else begin
                        settle_nxt = settle_cnt - SETTLE_BITS'(1);
                    end
                end
                S_ACQUIRE: begin
                    if (strobe) begin
                        total_nxt = total_inc;
                        good_nxt  = ldLocked ? good_inc : '0;
                        // Lock qualification takes priority over timeout.
                        if (good_nxt >= lock_thr) begin
                            nxt_st = S_LOCKED;
                        end else if (timeoutWindows != 8'd0 &&
                                     total_nxt >= timeoutWindows) begin
                            if (band_q != BAND_MAX) begin
                                band_nxt   = band_q + BAND_BITS'(1);
                                step_nxt   = 1'b1;
                                settle_nxt = settleCycles;
                                nxt_st     = S_SETTLE;
                            end else begin
                                fail_nxt = 1'b1;
                                nxt_st   = S_FAIL;
                            end
                        end
                    end
                end
                S_LOCKED: begin
                    if (strobe) begin
                        bad_nxt = ldLocked ? '0 : bad_inc;
                        if (bad_nxt >= unlock_thr) begin
                            nxt_st    = S_ACQUIRE;
                            lol_nxt   = 1'b1;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                            total_nxt = '0;
                        end
                    end
                end
                S_FAIL: begin
                    fail_nxt = 1'b1;
                end
                default: begin
                    nxt_st = S_IDLE;
                end
            endcase
        end
    end

    assign ldDivideEnable = div_en;
    assign pllLocked      = (cur_st == S_LOCKED);
    assign bandSel        = band_q;
    assign bandStep       = step_q;
    assign lossOfLock     = lol_q;
    assign acqFail        = fail_q;
    assign state          = cur_st;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized
// stimulus, all checked against a cycle-level behavioural model.
module tb_pll_lock_sequencer;

    localparam int WIN_BITS    = 4;
    localparam int SETTLE_BITS = 8;
    localparam int CONSEC_BITS = 3;
    localparam int BAND_BITS   = 3;
    localparam int WPER = 1 << WIN_BITS;
    localparam int CMAX = (1 << CONSEC_BITS) - 1;
    localparam int BMAX = (1 << BAND_BITS) - 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   enable = 1'b0;
    logic [BAND_BITS-1:0]   bandInit = '0;
    logic [SETTLE_BITS-1:0] settleCycles = '0;
    logic [CONSEC_BITS-1:0] lockCount = '0;
    logic [CONSEC_BITS-1:0] unlockCount = '0;
    logic [7:0]             timeoutWindows = '0;
    logic                   ldLocked = 1'b0;
    logic                   ldDivideEnable;
    logic [BAND_BITS-1:0]   bandSel;
    logic                   bandStep;
    logic                   pllLocked;
    logic                   lossOfLock;
    logic                   acqFail;
    logic [2:0]             state;

    pll_lock_sequencer #(
        .WIN_BITS(WIN_BITS),
        .SETTLE_BITS(SETTLE_BITS),
        .CONSEC_BITS(CONSEC_BITS),
        .BAND_BITS(BAND_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .bandInit(bandInit),
        .settleCycles(settleCycles),
        .lockCount(lockCount),
        .unlockCount(unlockCount),
        .timeoutWindows(timeoutWindows),
        .ldLocked(ldLocked),
        .ldDivideEnable(ldDivideEnable),
        .bandSel(bandSel),
        .bandStep(bandStep),
        .pllLocked(pllLocked),
        .lossOfLock(lossOfLock),
        .acqFail(acqFail),
        .state(state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Model: m_t counts cycles since the window enable went high.
    int m_st, m_t, m_settle, m_good, m_bad, m_total;
    int m_band, m_step, m_lol, m_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_settle = 0; m_good = 0; m_bad = 0;
        m_total = 0; m_band = 0; m_step = 0; m_lol = 0; m_fail = 0;
    endtask

    task automatic model_step();
        int  nst, lthr, uthr, tmo;
        bit  div, strb;
        div  = (m_st == 2) || (m_st == 3);
        strb = div && (m_t % WPER == 1) && (m_t > WPER);
        lthr = (lockCount == 0) ? 1 : int'(lockCount);
        uthr = (unlockCount == 0) ? 1 : int'(unlockCount);
        tmo  = int'(timeoutWindows);
        nst  = m_st;
        m_step = 0;
        m_lol  = 0;
        if (!enable) begin
            nst = 0;
        end else begin
            case (m_st)
                0: begin
                    nst = 1;
                    m_band = int'(bandInit);
                    m_settle = int'(settleCycles);
                    m_fail = 0;
                end
                1: begin
                    if (m_settle == 0) begin
                        nst = 2; m_good = 0; m_bad = 0; m_total = 0;
                    end else begin
                        m_settle--;
                    end
                end
                2: if (strb) begin
                    m_total = (m_total + 1 > 255) ? 255 : m_total + 1;
                    m_good = ldLocked ? ((m_good + 1 > CMAX) ? CMAX : m_good + 1) : 0;
                    if (m_good >= lthr) nst = 3;
                    else if (tmo != 0 && m_total >= tmo) begin
                        if (m_band < BMAX) begin
                            m_band++; m_step = 1; nst = 1;
                            m_settle = int'(settleCycles);
                        end else begin
                            nst = 4; m_fail = 1;
                        end
                    end
                end
                3: if (strb) begin
                    m_bad = ldLocked ? 0 : ((m_bad + 1 > CMAX) ? CMAX : m_bad + 1);
                    if (m_bad >= uthr) begin
                        nst = 2; m_lol = 1;
                        m_good = 0; m_bad = 0; m_total = 0;
                    end
                end
                default: m_fail = 1;
            endcase
        end
        m_t  = div ? m_t + 1 : 0;
        m_st = nst;
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_st));
        check("ldDivideEnable", 32'(ldDivideEnable), 32'((m_st == 2) || (m_st == 3)));
        check("pllLocked", 32'(pllLocked), 32'(m_st == 3));
        check("bandSel", 32'(bandSel), 32'(m_band));
        check("bandStep", 32'(bandStep), 32'(m_step));
        check("lossOfLock", 32'(lossOfLock), 32'(m_lol));
        check("acqFail", 32'(acqFail), 32'(m_fail));
    endtask

    task automatic run_cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    // Called at posedge+1; asserts reset between edges.
    task automatic mid_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_div"}, 32'(ldDivideEnable), 32'd0);
        check({tag, "_band"}, 32'(bandSel), 32'd0);
        check({tag, "_outs"}, 32'({pllLocked, bandStep, lossOfLock, acqFail}), 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    int n_div, n_lock, n_steps, n_lol, regime;
    bit done;

    initial begin
        model_reset();
        #22;
        compare_all();
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Lock acquisition timing from enable
        settleCycles = 8'd5; lockCount = 3'd3; unlockCount = 3'd2;
        timeoutWindows = 8'd0; ldLocked = 1'b1; bandInit = 3'd3;
        enable = 1'b1;
        n_div = 0; n_lock = 0; done = 0;
        for (int i = 1; i <= 200 && !done; i++) begin
            run_cycle();
            if (ldDivideEnable && n_div == 0) n_div = i;
            if (pllLocked) begin n_lock = i; done = 1; end
        end
        check("t1_div_rise", 32'(n_div), 32'd7);
        check("t1_lock_rise", 32'(n_lock), 32'd57);

        // Alternating windows hold lock; two bad windows drop it
        for (int w = 0; w < 6; w++) begin
            ldLocked = w[0];
            for (int k = 0; k < WPER; k++) run_cycle();
        end
        check("t2_hold", 32'(pllLocked), 32'd1);
        ldLocked = 1'b0;
        n_lol = 0;
        for (int k = 0; k < 3 * WPER; k++) begin
            run_cycle();
            if (lossOfLock) n_lol++;
        end
        check("t2_lol_cnt", 32'(n_lol), 32'd1);
        check("t2_state", 32'(state), 32'd2);

        // Asynchronous reset in ACQUIRE
        mid_reset("t5");

        // Timeout band stepping into FAIL
        bandInit = 3'd5; ldLocked = 1'b0; timeoutWindows = 8'd4;
        settleCycles = 8'd0; lockCount = 3'd3; enable = 1'b1;
        n_steps = 0; done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            run_cycle();
            if (bandStep) n_steps++;
            if (state == 3'd4) done = 1;
        end
        check("t3_steps", 32'(n_steps), 32'd2);
        check("t3_fail", 32'(acqFail), 32'd1);
        check("t3_div", 32'(ldDivideEnable), 32'd0);
        check("t3_band", 32'(bandSel), 32'd7);
        enable = 1'b0;
        run_cycle();
        run_cycle();
        enable = 1'b1;
        run_cycle();

        // Lock and timeout on the same strobe
        enable = 1'b0;
        run_cycle();
        bandInit = 3'd1; lockCount = 3'd3; timeoutWindows = 8'd3;
        ldLocked = 1'b1; enable = 1'b1;
        n_steps = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            run_cycle();
            if (bandStep) n_steps++;
            if (pllLocked) done = 1;
        end
        check("t4_steps", 32'(n_steps), 32'd0);
        check("t4_locked", 32'(pllLocked), 32'd1);

        // Disable from LOCKED, then re-enable with a new band
        enable = 1'b0;
        run_cycle();
        check("t6_state", 32'(state), 32'd0);
        check("t6_pll", 32'(pllLocked), 32'd0);
        check("t6_band_hold", 32'(bandSel), 32'd1);
        bandInit = 3'd2; enable = 1'b1;
        run_cycle();
        check("t6_band_load", 32'(bandSel), 32'd2);

        // Randomized operation
        regime = 0;
        for (int c = 0; c < 12000; c++) begin
            if (c % 48 == 0) regime = $urandom_range(0, 3);
            if (c % 300 == 0) begin
                settleCycles   = 8'($urandom_range(0, 7));
                lockCount      = 3'($urandom_range(0, 3));
                unlockCount    = 3'($urandom_range(0, 3));
                timeoutWindows = 8'($urandom_range(0, 6));
                bandInit       = 3'($urandom_range(0, 7));
            end
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            case (regime)
                0: ldLocked = 1'b1;
                1: ldLocked = 1'b0;
                2: ldLocked = ($urandom_range(0, 9) < 7);
                default: ldLocked = 1'($urandom_range(0, 1));
            endcase
            run_cycle();
            if (c == 6000) mid_reset("rnd_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Acquisition and lock-tracking controller for the PLL lock detector. It gates the detector's measurement windows through ldDivideEnable, filters the detector's per-window locked verdict into a debounced pllLocked status, and steps the coarse oscillator band when acquisition times out. It sits between the lock detector and the PLL's coarse-tune/status register logic.

Parameters:
WIN_BITS, 4, log2 of detector window length in cycles; must equal the detector's clock-counter width.
SETTLE_BITS, 8, width of the settle-time counter.
CONSEC_BITS, 3, width of the consecutive-window lock/unlock counters.
BAND_BITS, 3, width of the coarse band select.

Ports:
clock  in  1  block clock; same clock as the lock detector
reset  in  1  asynchronous, active-low reset
enable  in  1  start/keep sequencing; low returns to IDLE
bandInit  in  BAND_BITS  band loaded on IDLE->SETTLE
settleCycles  in  SETTLE_BITS  cycles to wait after any band change or start
lockCount  in  CONSEC_BITS  consecutive locked windows needed to declare lock; 0 treated as 1
unlockCount  in  CONSEC_BITS  consecutive unlocked windows needed to drop lock; 0 treated as 1
timeoutWindows  in  8  windows allowed in ACQUIRE before band step; 0 = never time out
ldLocked  in  1  detector locked output
ldDivideEnable  out  1  detector window enable
bandSel  out  BAND_BITS  coarse band select
bandStep  out  1  one-cycle pulse when bandSel increments
pllLocked  out  1  debounced lock status
lossOfLock  out  1  one-cycle pulse on LOCKED->ACQUIRE
acqFail  out  1  sticky acquisition failure
state  out  3  IDLE=0, SETTLE=1, ACQUIRE=2, LOCKED=3, FAIL=4

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0; bandSel=0; internal counters 0.
- Window counter winCnt (WIN_BITS): held 0 while ldDivideEnable=0, increments each cycle while 1, wraps at 2^WIN_BITS-1 -> 0.
- Sample strobe: asserted on the cycle winCnt==1, excluding the first window after ldDivideEnable rises (the detector has not yet evaluated). ldLocked is evaluated only on strobe cycles.
- IDLE: ldDivideEnable=0, pllLocked=0. enable=1 -> SETTLE next cycle; bandSel<=bandInit; settle counter<=settleCycles; acqFail<=0.
- SETTLE: ldDivideEnable=0. Counter decrements each cycle. When the counter is 0 -> ACQUIRE. settleCycles=0 gives exactly one SETTLE cycle. On entry to ACQUIRE: goodCnt=0, badCnt=0, winTotal=0.
- ACQUIRE: ldDivideEnable=1. On each strobe:
  - winTotal++ (saturates at 255).
  - ldLocked=1: goodCnt++. ldLocked=0: goodCnt=0.
  - goodCnt reaching max(lockCount,1) -> LOCKED; pllLocked=1 from the next cycle.
  - Otherwise, if timeoutWindows!=0 and winTotal reaches timeoutWindows:
    - bandSel<all-ones: bandSel++, bandStep pulse, -> SETTLE (reload settleCycles).
    - bandSel==all-ones: -> FAIL.
  - Lock qualification wins over timeout on the same strobe.
- LOCKED: ldDivideEnable=1, pllLocked=1. On each strobe:
  - ldLocked=0: badCnt++. ldLocked=1: badCnt=0.
  - badCnt reaching max(unlockCount,1) -> ACQUIRE; pllLocked=0; one-cycle lossOfLock pulse; bandSel unchanged; goodCnt, badCnt and winTotal cleared.
- FAIL: ldDivideEnable=0, acqFail=1 (sticky). Exit only via enable=0 -> IDLE; acqFail clears on the next IDLE->SETTLE.
- enable=0 in any state -> IDLE on the next edge; ldDivideEnable and pllLocked drop that edge; bandSel is held.
- Counter rules: goodCnt and badCnt saturate and never wrap.
- Input sampling: config inputs are sampled continuously. A change to lockCount, unlockCount or timeoutWindows mid-operation takes effect on the next strobe compare.
- Reset asserted mid-operation: immediate return to reset values, independent of clock.

Test Plan:
1. WIN_BITS=4, settleCycles=5, lockCount=3, ldLocked tied 1, enable rises at t0 -> SETTLE 6 cycles, then ACQUIRE. First strobe at 17 cycles after ldDivideEnable rises. pllLocked=1 the cycle after the 3rd strobe (cycle 50 after ACQUIRE entry).
2. In LOCKED, unlockCount=2; ldLocked alternates 0,1,0,1 per window -> pllLocked stays 1. Two consecutive 0 windows -> lossOfLock pulse, state=ACQUIRE, pllLocked=0.
3. ldLocked=0, timeoutWindows=4, bandInit=5 -> bandStep pulses after 4 strobes (bandSel=6), then after 4 more (bandSel=7). After 4 more -> FAIL with acqFail=1 and ldDivideEnable=0.
4. Same strobe reaches both goodCnt==lockCount and winTotal==timeoutWindows -> LOCKED; no bandStep.
5. Assert reset low mid-ACQUIRE between clock edges -> all outputs 0 immediately; bandSel=0; state=IDLE.
6. enable=0 while LOCKED -> next edge state=IDLE, pllLocked=0, bandSel retained. Re-enable with bandInit=2 -> bandSel=2.
